// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-to-memory bus sequencer.
// Access sizes, FSM states and a byte-count helper.
package cpu_bus_pkg;

  localparam logic [1:0] SZ_1B  = 2'd0;
  localparam logic [1:0] SZ_2B  = 2'd1;
  localparam logic [1:0] SZ_4B  = 2'd2;
  localparam logic [1:0] SZ_BAD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_1B:   return 1;
      SZ_2B:   return 2;
      SZ_4B:   return 4;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_bus_lane_map.sv
// Maps one beat of a core access onto bus byte lanes.
// Gives byte enables, write-lane data and read bytes placed at core lanes.
module cpu_bus_lane_map
  import cpu_bus_pkg::*;
#(
  parameter int BUS_BYTES = 1
) (
  input  logic [1:0]             off,
  input  logic [1:0]             size,
  input  logic [1:0]             beat,
  input  logic [31:0]            wdata,
  input  logic [8*BUS_BYTES-1:0] bus_rdata,
  output logic [BUS_BYTES-1:0]   be,
  output logic [8*BUS_BYTES-1:0] bus_wdata,
  output logic [31:0]            core_rdata
);

  always_comb begin
    be         = '0;
    bus_wdata  = '0;
    core_rdata = '0;
    for (int j = 0; j < BUS_BYTES; j++) begin
      int idx;
      // core byte index carried by bus lane j in this beat
      idx = int'(beat) * BUS_BYTES + j - int'(off);
      if (idx >= 0 && idx < size_bytes(size)) begin
        be[j] = 1'b1;
        bus_wdata[8*j +: 8] = wdata[8*idx[1:0] +: 8];
        core_rdata[8*idx[1:0] +: 8] = bus_rdata[8*j +: 8];
      end
    end
  end

endmodule

// File: rtl/cpu_bus_seq.sv
// Splits a 1/2/4-byte core access into aligned little-endian bus beats.
// Handles target wait states and aborts a beat on timeout.
module cpu_bus_seq
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req,
  input  logic                   i_we,
  input  logic [1:0]             i_size,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [31:0]            i_wdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [31:0]            o_rdata,
  output logic                   o_bus_clk,
  output logic                   o_bus_we,
  output logic [ADDR_W-1:0]      o_bus_addr,
  output logic [BUS_BYTES-1:0]   o_bus_be,
  output logic [8*BUS_BYTES-1:0] o_bus_data,
  input  logic [8*BUS_BYTES-1:0] i_bus_data,
  input  logic                   i_bus_data_ready
);

  localparam int LOG = $clog2(BUS_BYTES);
  localparam int WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        beat_q;
  logic [WW-1:0]     wait_q;
  logic [31:0]       asm_q;
  logic [31:0]       rdata_q;

  logic [1:0]             off;
  logic [3:0]             span;
  logic [3:0]             nbeats;
  logic                   last;
  logic                   timeout_hit;
  logic                   drive;
  logic [ADDR_W-1:0]      beat_addr;
  logic [BUS_BYTES-1:0]   be;
  logic [8*BUS_BYTES-1:0] lane_wdata;
  logic [31:0]            lane_rdata;
  logic [31:0]            asm_nx;

  assign off    = addr_q[1:0] & 2'(BUS_BYTES - 1);
  assign span   = 4'(off) + 4'(size_bytes(size_q));
  assign nbeats = 4'((span + 4'(BUS_BYTES - 1)) >> LOG);
  assign last   = (4'(beat_q) + 4'd1) == nbeats;

  assign timeout_hit = (TIMEOUT != 0) &&
                       (wait_q == WW'(TIMEOUT - 1));

  // beat address wraps modulo 2^ADDR_W by construction
  assign beat_addr = (addr_q & ~ADDR_W'(BUS_BYTES - 1)) +
                     (ADDR_W'(beat_q) << LOG);

  cpu_bus_lane_map #(
    .BUS_BYTES(BUS_BYTES)
  ) u_lane_map (
    .off       (off),
    .size      (size_q),
    .beat      (beat_q),
    .wdata     (wdata_q),
    .bus_rdata (i_bus_data),
    .be        (be),
    .bus_wdata (lane_wdata),
    .core_rdata(lane_rdata)
  );

  assign asm_nx = asm_q | lane_rdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (i_req)
          state_d = (i_size == SZ_BAD) ? ST_ERR : ST_SETUP;
      ST_SETUP:
        state_d = ST_STROBE;
      ST_STROBE:
        if (i_bus_data_ready)
          state_d = last ? ST_DONE : ST_SETUP;
        else if (timeout_hit)
          state_d = ST_ERR;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE:
          if (i_req) begin
            we_q    <= i_we;
            size_q  <= i_size;
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            beat_q  <= '0;
            asm_q   <= '0;
          end
        ST_SETUP:
          wait_q <= '0;
        ST_STROBE:
          if (i_bus_data_ready) begin
            beat_q <= beat_q + 2'd1;
            asm_q  <= asm_nx;
            if (last && !we_q)
              rdata_q <= asm_nx;
          end else if (TIMEOUT != 0) begin
            wait_q <= wait_q + 1'b1;
          end
        default: ;
      endcase
    end
  end

  assign drive      = (state_q == ST_SETUP) ||
                      (state_q == ST_STROBE);
  assign o_busy     = state_q != ST_IDLE;
  assign o_done     = (state_q == ST_DONE) ||
                      (state_q == ST_ERR);
  assign o_err      = state_q == ST_ERR;
  assign o_rdata    = rdata_q;
  assign o_bus_clk  = state_q == ST_STROBE;
  assign o_bus_we   = drive && we_q;
  assign o_bus_addr = drive ? beat_addr : '0;
  assign o_bus_be   = drive ? be : '0;
  assign o_bus_data = (drive && we_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Bench for cpu_bus_seq at bus widths 1, 2 and 4 bytes.
// Memory byte at address a reads back as a[7:0].
module tb_cpu_bus_seq;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          wait_n;
  bit          rdy_hi;

  logic        req1, busy1, done1, err1, bclk1, bwe1, brdy1;
  logic [31:0] rdata1, baddr1;
  logic [0:0]  bbe1;
  logic [7:0]  bdo1, bdi1;

  logic        req2, busy2, done2, err2, bclk2, bwe2, brdy2;
  logic [31:0] rdata2, baddr2;
  logic [1:0]  bbe2;
  logic [15:0] bdo2, bdi2;

  logic        req4, busy4, done4, err4, bclk4, bwe4, brdy4;
  logic [31:0] rdata4, baddr4;
  logic [3:0]  bbe4;
  logic [31:0] bdo4, bdi4;

  int checks = 0;
  int errors = 0;

  cpu_bus_seq #(.ADDR_W(32), .BUS_BYTES(1), .TIMEOUT(4)) u1 (
    .i_clk(clk), .i_rst(rst_n), .i_req(req1), .i_we(we),
    .i_size(size), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .o_rdata(rdata1),
    .o_bus_clk(bclk1), .o_bus_we(bwe1), .o_bus_addr(baddr1),
    .o_bus_be(bbe1), .o_bus_data(bdo1), .i_bus_data(bdi1),
    .i_bus_data_ready(brdy1));

  cpu_bus_seq #(.ADDR_W(32), .BUS_BYTES(2), .TIMEOUT(255)) u2 (
    .i_clk(clk), .i_rst(rst_n), .i_req(req2), .i_we(we),
    .i_size(size), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy2), .o_done(done2), .o_err(err2), .o_rdata(rdata2),
    .o_bus_clk(bclk2), .o_bus_we(bwe2), .o_bus_addr(baddr2),
    .o_bus_be(bbe2), .o_bus_data(bdo2), .i_bus_data(bdi2),
    .i_bus_data_ready(brdy2));

  cpu_bus_seq #(.ADDR_W(32), .BUS_BYTES(4), .TIMEOUT(255)) u4 (
    .i_clk(clk), .i_rst(rst_n), .i_req(req4), .i_we(we),
    .i_size(size), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy4), .o_done(done4), .o_err(err4), .o_rdata(rdata4),
    .o_bus_clk(bclk4), .o_bus_we(bwe4), .o_bus_addr(baddr4),
    .o_bus_be(bbe4), .o_bus_data(bdo4), .i_bus_data(bdi4),
    .i_bus_data_ready(brdy4));

  always #5 clk = ~clk;

  // responders: ready after wait_n strobe cycles, disabled lanes read EE
  int wc1, wc2, wc4, nlog;
  logic [31:0] log_a [16];
  logic [3:0]  log_be [16];
  logic [31:0] log_d [16];

  always @(negedge clk) begin
    brdy1 = 1'b0;
    bdi1 = 8'hEE;
    if (bclk1) begin
      if (wc1 >= wait_n) begin
        brdy1 = 1'b1;
        if (bbe1[0]) bdi1 = baddr1[7:0];
      end
      wc1++;
    end else wc1 = 0;
    if (rdy_hi) brdy1 = 1'b1;
  end

  always @(negedge clk) begin
    brdy2 = 1'b0;
    bdi2 = {2{8'hEE}};
    if (bclk2) begin
      if (wc2 >= wait_n) begin
        brdy2 = 1'b1;
        for (int j = 0; j < 2; j++)
          if (bbe2[j]) bdi2[8*j +: 8] = 8'(baddr2 + 32'(j));
      end
      wc2++;
    end else wc2 = 0;
    if (rdy_hi) brdy2 = 1'b1;
  end

  always @(negedge clk) begin
    brdy4 = 1'b0;
    bdi4 = {4{8'hEE}};
    if (bclk4) begin
      if (wc4 >= wait_n) begin
        brdy4 = 1'b1;
        for (int j = 0; j < 4; j++)
          if (bbe4[j]) bdi4[8*j +: 8] = 8'(baddr4 + 32'(j));
        log_a[nlog % 16]  = baddr4;
        log_be[nlog % 16] = bbe4;
        log_d[nlog % 16]  = bdo4;
        nlog++;
      end
      wc4++;
    end else wc4 = 0;
    if (rdy_hi) brdy4 = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v);
    case (s)
      1: req1 = v;
      2: req2 = v;
      default: req4 = v;
    endcase
  endtask

  function automatic logic done_of(input int s);
    case (s)
      1: return done1;
      2: return done2;
      default: return done4;
    endcase
  endfunction

  function automatic logic err_of(input int s);
    case (s)
      1: return err1;
      2: return err2;
      default: return err4;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      1: return busy1;
      2: return busy2;
      default: return busy4;
    endcase
  endfunction

  function automatic logic bclk_of(input int s);
    case (s)
      1: return bclk1;
      2: return bclk2;
      default: return bclk4;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int s);
    case (s)
      1: return rdata1;
      2: return rdata2;
      default: return rdata4;
    endcase
  endfunction

  // cycle n = n-th cycle after the edge that samples i_req
  task automatic run(input int s, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     output int cyc, output logic e,
                     output logic [31:0] rd, output bit saw);
    @(negedge clk);
    we = w;
    size = sz;
    addr = a;
    wdata = d;
    set_req(s, 1'b1);
    @(posedge clk);
    #1;
    set_req(s, 1'b0);
    cyc = 1;
    saw = 1'b0;
    while (!done_of(s) && cyc < 40) begin
      if (bclk_of(s)) saw = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    e = err_of(s);
    rd = rdata_of(s);
  endtask

  typedef struct {
    int          sel;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    int          wt;
    bit          rhi;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t tv [17];

  int          cyc, base, k, seen;
  logic        e;
  logic [31:0] rd;
  bit          saw, nd;

  initial begin
    tv[0]  = '{1, 1'b0, 2'd2, 32'h1001,     0, 0,   0, 32'h04030201, 0, 9};
    tv[1]  = '{1, 1'b0, 2'd0, 32'h55,       0, 0,   0, 32'h00000055, 0, 3};
    tv[2]  = '{1, 1'b0, 2'd1, 32'h20,       0, 2,   0, 32'h00002120, 0, 9};
    tv[3]  = '{1, 1'b1, 2'd1, 32'h40, 32'h1234, 0,  0, 32'h00002120, 0, 5};
    tv[4]  = '{1, 1'b0, 2'd2, 32'hFFFFFFFE, 0, 0,   0, 32'h0100FFFE, 0, 9};
    tv[5]  = '{1, 1'b0, 2'd3, 32'h0,        0, 0,   0, 32'h0100FFFE, 1, 1};
    tv[6]  = '{1, 1'b0, 2'd0, 32'h7,        0, 100, 0, 32'h0100FFFE, 1, 6};
    tv[7]  = '{1, 1'b0, 2'd0, 32'h9,        0, 3,   0, 32'h00000009, 0, 6};
    tv[8]  = '{1, 1'b0, 2'd1, 32'h30,       0, 0,   1, 32'h00003130, 0, 5};
    tv[9]  = '{2, 1'b0, 2'd0, 32'h10,       0, 3,   0, 32'h00000010, 0, 6};
    tv[10] = '{2, 1'b0, 2'd2, 32'h11,       0, 0,   0, 32'h14131211, 0, 7};
    tv[11] = '{2, 1'b0, 2'd1, 32'h23,       0, 1,   0, 32'h00002423, 0, 7};
    tv[12] = '{4, 1'b0, 2'd2, 32'h2003,     0, 0,   0, 32'h06050403, 0, 5};
    tv[13] = '{4, 1'b0, 2'd0, 32'h2002,     0, 0,   0, 32'h00000002, 0, 3};
    tv[14] = '{4, 1'b0, 2'd2, 32'h100,      0, 0,   0, 32'h03020100, 0, 3};
    tv[15] = '{4, 1'b1, 2'd1, 32'h2003, 32'hBEEF, 0, 0, 32'h03020100, 0, 5};
    tv[16] = '{4, 1'b0, 2'd1, 32'h2001,     0, 2,   0, 32'h00000201, 0, 5};

    clk = 0;
    rst_n = 0;
    req1 = 0;
    req2 = 0;
    req4 = 0;
    we = 0;
    size = 0;
    addr = 0;
    wdata = 0;
    wait_n = 0;
    rdy_hi = 0;
    #12;
    chk("rst_ctl1", {27'd0, busy1, done1, err1, bclk1, bwe1}, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_addr1", baddr1, 0);
    chk("rst_ctl4", {23'd0, busy4, done4, err4, bclk4, bbe4}, 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 17; i++) begin
      wait_n = tv[i].wt;
      rdy_hi = tv[i].rhi;
      run(tv[i].sel, tv[i].we, tv[i].sz, tv[i].a, tv[i].d,
          cyc, e, rd, saw);
      chk($sformatf("v%0d_cyc", i), cyc, tv[i].exp_cyc);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, tv[i].exp_err});
      chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rd);
      if (tv[i].sz == 2'd3)
        chk($sformatf("v%0d_noclk", i), {31'd0, saw}, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle", i), {31'd0, busy_of(tv[i].sel)}, 0);
    end
    wait_n = 0;
    rdy_hi = 0;

    // split 2-byte write on the 4-byte bus
    base = nlog;
    run(4, 1'b1, 2'd1, 32'h2003, 32'hBEEF, cyc, e, rd, saw);
    chk("wr_nbeats", 32'(nlog - base), 2);
    chk("wr_b0_addr", log_a[base % 16], 32'h2000);
    chk("wr_b0_be", {28'd0, log_be[base % 16]}, 32'h8);
    chk("wr_b0_data", {24'd0, log_d[base % 16][31:24]}, 32'hEF);
    chk("wr_b1_addr", log_a[(base + 1) % 16], 32'h2004);
    chk("wr_b1_be", {28'd0, log_be[(base + 1) % 16]}, 32'h1);
    chk("wr_b1_data", {24'd0, log_d[(base + 1) % 16][7:0]}, 32'hBE);

    // reset during the strobe of the second beat
    @(negedge clk);
    we = 0;
    size = 2'd2;
    addr = 32'h50;
    req1 = 1;
    @(posedge clk);
    #1;
    req1 = 0;
    seen = 0;
    k = 0;
    while (seen < 2 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (bclk1) seen++;
    end
    chk("rst_reach_beat2", seen, 2);
    #2;
    rst_n = 0;
    #1;
    chk("arst_ctl", {27'd0, busy1, done1, err1, bclk1, bwe1}, 0);
    chk("arst_rdata", rdata1, 0);
    chk("arst_addr", baddr1, 0);
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done1) nd = 1;
    end
    chk("arst_nodone", {31'd0, nd}, 0);
    @(negedge clk);
    rst_n = 1;
    run(1, 1'b0, 2'd0, 32'h33, 0, cyc, e, rd, saw);
    chk("post_rst_cyc", cyc, 3);
    chk("post_rst_rdata", rd, 32'h33);
    chk("post_rst_err", {31'd0, e}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
